fmap_writer: RTL

Write-side counterpart of the layer read iterator. Sits at the output of a conv / relu / max_pool stage, takes that stage's `q_en` / `q` result stream (CH_NUM planes in parallel, one output pixel per strobe) and serialises it into a single-port feature-map RAM, one channel word per cycle. Produces plane-major addresses so the next layer's iterator reads the map directly. Reports busy/done and flags dropped results.

---
 rtl/fmap_writer_pkg.sv | 13 +
 rtl/fmap_fifo.sv | 56 +++++
 rtl/fmap_writer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fmap_writer_pkg.sv
// Shared widths and FSM state type for the feature-map writer.
package fmap_writer_pkg;

  localparam int unsigned WDP         = 16;
  localparam int unsigned WD          = 16;
  localparam int unsigned W_FMAP_ADDR = 16;

  typedef enum logic {
    IDLE,
    WRITE
  } fmap_state_t;

endpackage

// File: rtl/fmap_fifo.sv
// Pixel-vector FIFO between the upstream result strobe and the RAM write serialiser.
module fmap_fifo #(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         more
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0] ONE_LVL  = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [AW:0]  level;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    level   = wptr - rptr;
    empty   = (level == '0);
    full    = (level == FULL_LVL);
    more    = (level > ONE_LVL);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fmap_writer.sv
// Serialises CH_NUM-wide result pixels into a single-port feature-map RAM,
// one channel word per cycle, at plane-major addresses.
module fmap_writer
  import fmap_writer_pkg::*;
#(
  parameter int unsigned CH_NUM     = 6,
  parameter int unsigned OUT_W      = 28,
  parameter int unsigned OUT_H      = 28,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    go,
  input  logic                    en,
  input  logic [WDP*CH_NUM-1:0]   data_i,
  output logic                    cenb,
  output logic [W_FMAP_ADDR-1:0]  ab,
  output logic [WDP-1:0]          db,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int unsigned CW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned PLANE = OUT_W * OUT_H;
  localparam logic [CW-1:0] CH_LAST  = CW'(CH_NUM - 1);
  localparam logic [XW-1:0] COL_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(OUT_H - 1);

  fmap_state_t state, state_next;
  logic [CW-1:0]         ch;
  logic [XW-1:0]         col;
  logic [YW-1:0]         row;
  logic                  armed;
  logic                  fin;
  logic [WDP*CH_NUM-1:0] head;
  logic                  full, empty, more;
  logic                  fire, pop, last_pop, leave, push, drop, clr;
  logic [31:0]           addr;
  logic [WDP-1:0]        wd;

  fmap_fifo #(
    .W     (WDP * CH_NUM),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (data_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .more  (more)
  );

  // IDLE issues channel 0 on the same edge it enters WRITE, which gives the
  // one-cycle strobe-to-write latency; WRITE then carries on from channel 1.
  always_comb begin
    fire       = (state == WRITE) || ((state == IDLE) && !empty);
    pop        = fire && (ch == CH_LAST);
    last_pop   = pop && (col == COL_LAST) && (row == ROW_LAST);
    leave      = pop && (last_pop || !more);
    push       = en && armed && !fin && !go;
    drop       = push && full && !pop;
    clr        = go || last_pop;
    state_next = state;
    case (state)
      IDLE:    if (!empty && !leave) state_next = WRITE;
      WRITE:   if (leave) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addr = BASE_ADDR + 32'(ch) * PLANE + 32'(row) * OUT_W + 32'(col);
    wd   = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (ch == CW'(i)) wd = head[(CH_NUM-1-i)*WDP +: WDP];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   state <= IDLE;
    else if (go) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch       <= '0;
      col      <= '0;
      row      <= '0;
      armed    <= 1'b0;
      fin      <= 1'b0;
      cenb     <= 1'b1;
      ab       <= '0;
      db       <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (go) begin
      ch       <= '0;
      col      <= '0;
      row      <= '0;
      armed    <= 1'b1;
      fin      <= 1'b0;
      cenb     <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cenb <= !fire;
      if (fire) begin
        ab <= addr[W_FMAP_ADDR-1:0];
        db <= wd;
        ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
      end
      if (pop) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (drop) overflow <= 1'b1;
      // done and the fall of busy land one cycle after the final write.
      fin  <= last_pop;
      done <= fin;
      if (fin) armed <= 1'b0;
    end
  end

  assign busy = armed;

endmodule
